pipe_mux: RTL
=============

Name: pipe_mux

Overview:
- Parametrised N-way, W-bit selector with a registered output stage and a valid/ready handshake; successor to the combinational 16-input selector used in the datapath.
- The selected word is captured in an output register. A one-entry skid buffer lets the block accept one word per cycle under back-pressure without a combinational ready path.
- Used in pipeline boundaries for forwarding-source and writeback-source selection, where the select must be registered together with the data.

Parameters:
- NUM, 16, number of data inputs (2..64).
- SELW, 4, select width; must satisfy 2**SELW >= NUM.
- WIDTH, 32, data width in bits.
- DEFVAL, 0, WIDTH-bit value driven for an out-of-range select.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word (sel, d) is valid.
- in_ready  output  1  block can accept; registered, no combinational path from out_ready.
- sel  input  SELW  binary select, sampled on accept.
- d  input  NUM*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  y / out_sel / sel_err are valid.
- out_ready  input  1  downstream accepts the current output.
- y  output  WIDTH  selected data.
- out_sel  output  SELW  select value that produced y.
- sel_err  output  1  sel was >= NUM when accepted (y = DEFVAL).

Behaviour:
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Select function, combinational on sel and d:
  - word = d[sel*WIDTH +: WIDTH] when sel < NUM;
  - otherwise word = DEFVAL and err = 1.
  - The result is captured only on accept.
- State: main register (out_valid, y, out_sel, sel_err) and skid register (skid_v plus the same fields).
- Main register update on each clock edge:
  - If main is empty or Drain: load skid if skid_v; else load the input if Accept; else out_valid <= 0.
  - If main is full and not Drain: hold.
- Skid register update:
  - Loaded when Accept, main full and not Drain.
  - Cleared when its contents move to main.
  - Never loaded while skid_v = 1, because in_ready is 0.
- in_ready register: next value = !skid_v_next.
- Latency and throughput:
  - First accepted word appears on out_valid the cycle after Accept (1-cycle latency).
  - Sustained 1 word/cycle while out_ready = 1.
- Ordering: strict FIFO order, with a maximum of 2 words in flight.
- Output stability: outputs change only on Drain or when main is empty (AXI-style stable-while-stalled).
- Simultaneous Accept and Drain with skid empty: input goes straight to main; skid untouched.
- Reset, asynchronous and effective immediately, including mid-transfer:
  - out_valid = 0, y = 0, out_sel = 0, sel_err = 0, skid_v = 0, in_ready = 0.
  - in_ready rises on the first clock edge after rst deasserts.
  - All in-flight words are discarded.
- Select wrap-around: none. Any sel >= NUM, including when NUM is not a power of two, produces DEFVAL with sel_err = 1. No modulo indexing.
- X-safety: an unaccepted sel or d has no effect on state.

Test Plan:
- Reset, then idle: in_ready = 0 during rst and 1 one cycle after release. out_valid = 0, y = 0.
- Streaming, out_ready = 1: d_k = 32'h1000_0000+k, sel sequence 0, 5, 15, 7 on consecutive cycles. Expected y = 1000_0000, 1000_0005, 1000_000F, 1000_0007 one cycle later each, out_valid continuous, sel_err = 0.
- Back-pressure with NUM = 12: hold out_ready = 0 and offer sel = 3, then 13, then 2.
  - Word sel = 3 sits in main; word sel = 13 is accepted into skid; in_ready drops to 0; word sel = 2 stalls.
  - Release out_ready: outputs are y = d3; then y = DEFVAL with sel_err = 1 and out_sel = 13; then y = d2. No loss, no duplication.
- Stall stability: with out_valid = 1 and out_ready = 0 for 5 cycles while d toggles, y / out_sel / sel_err stay constant.
- Mid-operation reset: with both entries full, pulse rst between clock edges. out_valid and in_ready fall immediately, and no stale word emerges after release.
- Random 10k-cycle run with random in_valid / out_ready and NUM = 5, SELW = 3: a scoreboard checks order, values, sel_err, and that in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_mux_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_mux_if : handshake bus for pipe_mux (upstream + downstream) |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
interface pipe_mux_if #(
  parameter int NUM   = 16,
  parameter int SELW  = 4,
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      sel;
  logic [NUM*WIDTH-1:0] d;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     y;
  logic [SELW-1:0]      out_sel;
  logic                 sel_err;

  modport master (
    output in_valid, sel, d, out_ready,
    input  in_ready, out_valid, y, out_sel, sel_err
  );

  modport slave (
    input  in_valid, sel, d, out_ready,
    output in_ready, out_valid, y, out_sel, sel_err
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_mux : N-way W-bit selector, registered output + skid buffer |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pipe_mux #(
  parameter int              NUM    = 16,
  parameter int              SELW   = 4,
  parameter int              WIDTH  = 32,
  parameter logic [WIDTH-1:0] DEFVAL = '0
) (
  input wire        clk,
  input wire        rst,
  pipe_mux_if.slave bus
);

  logic [WIDTH-1:0] word;
  logic             word_err;

  logic             main_v, main_v_n;
  logic [WIDTH-1:0] main_y, main_y_n;
  logic [SELW-1:0]  main_sel, main_sel_n;
  logic             main_err, main_err_n;

  logic             skid_v, skid_v_n;
  logic [WIDTH-1:0] skid_y, skid_y_n;
  logic [SELW-1:0]  skid_sel, skid_sel_n;
  logic             skid_err, skid_err_n;

  logic             in_ready_r;
  logic             accept;
  logic             drain;

  // Explicit compare per input: selects beyond NUM never alias onto a real input.
  always_comb begin
    word     = DEFVAL;
    word_err = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      if (bus.sel == SELW'(k)) begin
        word     = bus.d[k*WIDTH +: WIDTH];
        word_err = 1'b0;
      end
    end
  end

  assign accept = bus.in_valid & in_ready_r;
  assign drain  = main_v & bus.out_ready;

  always_comb begin
    main_v_n   = main_v;
    main_y_n   = main_y;
    main_sel_n = main_sel;
    main_err_n = main_err;
    skid_v_n   = skid_v;
    skid_y_n   = skid_y;
    skid_sel_n = skid_sel;
    skid_err_n = skid_err;
    if (!main_v || drain) begin
      if (skid_v) begin
        main_v_n   = 1'b1;
        main_y_n   = skid_y;
        main_sel_n = skid_sel;
        main_err_n = skid_err;
        skid_v_n   = 1'b0;
      end else if (accept) begin
        main_v_n   = 1'b1;
        main_y_n   = word;
        main_sel_n = bus.sel;
        main_err_n = word_err;
      end else begin
        main_v_n   = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the word; in_ready drops next cycle.
      skid_v_n   = 1'b1;
      skid_y_n   = word;
      skid_sel_n = bus.sel;
      skid_err_n = word_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v     <= 1'b0;
      main_y     <= '0;
      main_sel   <= '0;
      main_err   <= 1'b0;
      skid_v     <= 1'b0;
      skid_y     <= '0;
      skid_sel   <= '0;
      skid_err   <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      main_v     <= main_v_n;
      main_y     <= main_y_n;
      main_sel   <= main_sel_n;
      main_err   <= main_err_n;
      skid_v     <= skid_v_n;
      skid_y     <= skid_y_n;
      skid_sel   <= skid_sel_n;
      skid_err   <= skid_err_n;
      in_ready_r <= !skid_v_n;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = main_v;
  assign bus.y         = main_y;
  assign bus.out_sel   = main_sel;
  assign bus.sel_err   = main_err;

endmodule
`default_nettype wire
